// File: rtl/wb_stage.sv
// Writeback stage: 2-write-port register file, architectural flags, conflict pulse and retire counter.
// Optional macro WB_BYPASS_EN makes the read ports and flag outputs write-through.
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_enable,
    input  logic              p4_alu_regWrite,
    input  logic [REG_AW-1:0] p4_alu_rd,
    input  logic [DATA_W-1:0] p4_alu_aluOut,
    input  logic              p4_mem_regWrite,
    input  logic [REG_AW-1:0] p4_mem_rd,
    input  logic [DATA_W-1:0] p4_mem_memOut,
    input  logic              p4_flag_z,
    input  logic              p4_flag_n,
    input  logic              p4_flag_c,
    input  logic              p4_flag_v,
    input  logic [REG_AW-1:0] rd_alu_rs_addr,
    input  logic [REG_AW-1:0] rd_alu_rt_addr,
    input  logic [REG_AW-1:0] rd_mem_rs_addr,
    output logic [DATA_W-1:0] rd_alu_rs_data,
    output logic [DATA_W-1:0] rd_alu_rt_data,
    output logic [DATA_W-1:0] rd_mem_rs_data,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              flag_v,
    output logic              wb_conflict,
    output logic [CNT_W-1:0]  retire_count
);
    localparam int NREGS = 1 << REG_AW;

    logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [3:0]                   flags_q, flags_d;
    logic                         conflict_q, conflict_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;

    // MEM slot is applied after ALU slot so it wins a same-rd collision.
    always_comb begin
        regs_d     = regs_q;
        flags_d    = flags_q;
        cnt_d      = cnt_q;
        conflict_d = 1'b0;
        if (wb_enable) begin
            if (p4_alu_regWrite) regs_d[p4_alu_rd] = p4_alu_aluOut;
            if (p4_mem_regWrite) regs_d[p4_mem_rd] = p4_mem_memOut;
            flags_d    = {p4_flag_z, p4_flag_n, p4_flag_c, p4_flag_v};
            cnt_d      = cnt_q + CNT_W'(p4_alu_regWrite) + CNT_W'(p4_mem_regWrite);
            conflict_d = p4_alu_regWrite & p4_mem_regWrite & (p4_alu_rd == p4_mem_rd);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q     <= '0;
            flags_q    <= '0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            regs_q     <= regs_d;
            flags_q    <= flags_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef WB_BYPASS_EN
    // Bypass is suppressed during reset so reads show the cleared file.
    logic byp_en;
    assign byp_en = wb_enable & ~reset;

    function automatic logic [DATA_W-1:0] rd_port(input logic [REG_AW-1:0] a);
        if (byp_en && p4_mem_regWrite && (a == p4_mem_rd))      return p4_mem_memOut;
        else if (byp_en && p4_alu_regWrite && (a == p4_alu_rd)) return p4_alu_aluOut;
        else                                                    return regs_q[a];
    endfunction

    assign {flag_z, flag_n, flag_c, flag_v} =
        byp_en ? {p4_flag_z, p4_flag_n, p4_flag_c, p4_flag_v} : flags_q;
`else
    function automatic logic [DATA_W-1:0] rd_port(input logic [REG_AW-1:0] a);
        return regs_q[a];
    endfunction

    assign {flag_z, flag_n, flag_c, flag_v} = flags_q;
`endif

    assign rd_alu_rs_data = rd_port(rd_alu_rs_addr);
    assign rd_alu_rt_data = rd_port(rd_alu_rt_addr);
    assign rd_mem_rs_data = rd_port(rd_mem_rs_addr);
    assign wb_conflict    = conflict_q;
    assign retire_count   = cnt_q;
endmodule

// File: tb/tb_wb_stage.sv
// Randomised bench for wb_stage with a register-array reference model, plus directed literal cases.
// A second instance with a 4-bit counter exercises counter wrap-around.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        aw, mw;
    logic [2:0]  ard, mrd;
    logic [31:0] av, mv;
    logic [3:0]  fl;
    logic [2:0]  ra0, ra1, ra2;

    logic [31:0] d0, d1, d2;
    logic        fz, fn, fc, fv, conf;
    logic [31:0] cnt;

    logic [31:0] s0, s1, s2;
    logic        sfz, sfn, sfc, sfv, sconf;
    logic [3:0]  scnt;

    int errors = 0;
    int checks = 0;

    bit [31:0]   mregs [8];
    bit [3:0]    mflags;
    bit          mconf;
    int unsigned mcnt;
    int unsigned mcnt4;

    always #5 clk = ~clk;

    wb_stage #(.DATA_W(32), .REG_AW(3), .CNT_W(32)) u_dut (
        .clk(clk), .reset(rst), .wb_enable(en),
        .p4_alu_regWrite(aw), .p4_alu_rd(ard), .p4_alu_aluOut(av),
        .p4_mem_regWrite(mw), .p4_mem_rd(mrd), .p4_mem_memOut(mv),
        .p4_flag_z(fl[3]), .p4_flag_n(fl[2]), .p4_flag_c(fl[1]), .p4_flag_v(fl[0]),
        .rd_alu_rs_addr(ra0), .rd_alu_rt_addr(ra1), .rd_mem_rs_addr(ra2),
        .rd_alu_rs_data(d0), .rd_alu_rt_data(d1), .rd_mem_rs_data(d2),
        .flag_z(fz), .flag_n(fn), .flag_c(fc), .flag_v(fv),
        .wb_conflict(conf), .retire_count(cnt)
    );

    wb_stage #(.DATA_W(32), .REG_AW(3), .CNT_W(4)) u_dut_w (
        .clk(clk), .reset(rst), .wb_enable(en),
        .p4_alu_regWrite(aw), .p4_alu_rd(ard), .p4_alu_aluOut(av),
        .p4_mem_regWrite(mw), .p4_mem_rd(mrd), .p4_mem_memOut(mv),
        .p4_flag_z(fl[3]), .p4_flag_n(fl[2]), .p4_flag_c(fl[1]), .p4_flag_v(fl[0]),
        .rd_alu_rs_addr(ra0), .rd_alu_rt_addr(ra1), .rd_mem_rs_addr(ra2),
        .rd_alu_rs_data(s0), .rd_alu_rt_data(s1), .rd_mem_rs_data(s2),
        .flag_z(sfz), .flag_n(sfn), .flag_c(sfc), .flag_v(sfv),
        .wb_conflict(sconf), .retire_count(scnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state updated once per committed edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (mregs[i]) mregs[i] = '0;
            mflags = '0; mconf = 1'b0; mcnt = 0; mcnt4 = 0;
        end else begin
            mconf = 1'b0;
            if (en) begin
                if (aw) mregs[ard] = av;
                if (mw) mregs[mrd] = mv;
                mflags = fl;
                mconf  = aw && mw && (ard == mrd);
                mcnt   = mcnt + int'(aw) + int'(mw);
                mcnt4  = (mcnt4 + int'(aw) + int'(mw)) % 16;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
`ifdef WB_BYPASS_EN
        if (en && !rst && mw && a == mrd) return mv;
        if (en && !rst && aw && a == ard) return av;
`endif
        return mregs[a];
    endfunction

    function automatic logic [3:0] exp_flags();
`ifdef WB_BYPASS_EN
        if (en && !rst) return fl;
`endif
        return mflags;
    endfunction

    always @(negedge clk) begin
        chk("rd_alu_rs", d0, exp_rd(ra0));
        chk("rd_alu_rt", d1, exp_rd(ra1));
        chk("rd_mem_rs", d2, exp_rd(ra2));
        chk("flags", {28'd0, fz, fn, fc, fv}, {28'd0, exp_flags()});
        chk("wb_conflict", {31'd0, conf}, {31'd0, mconf});
        chk("retire_count", cnt, mcnt);
        chk("retire_count_w4", {28'd0, scnt}, mcnt4);
    end

    task automatic drv(input logic e, input logic a_w, input logic [2:0] a_rd, input logic [31:0] a_v,
                       input logic m_w, input logic [2:0] m_rd, input logic [31:0] m_v,
                       input logic [3:0] f, input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2);
        en = e; aw = a_w; ard = a_rd; av = a_v; mw = m_w; mrd = m_rd; mv = m_v;
        fl = f; ra0 = r0; ra1 = r1; ra2 = r2;
    endtask

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset_rd", d0, 32'h0);
        chk("reset_cnt", cnt, 32'h0);
        #1 rst = 1'b0;

        // Dual write to distinct registers
        drv(1, 1, 1, 32'h11, 1, 2, 32'h22, 4'b0000, 1, 2, 0);
        @(negedge clk);
        chk("dual_r1", d0, 32'h11);
        chk("dual_r2", d1, 32'h22);
        chk("dual_cnt", cnt, 32'd2);
        chk("dual_conf", {31'd0, conf}, 32'd0);
        #1;

        // Same-rd collision: MEM wins, pulse for one cycle, counts 2
        drv(1, 1, 5, 32'hAAAA, 1, 5, 32'hBBBB, 4'b0000, 5, 5, 5);
        @(negedge clk);
        chk("coll_r5", d0, 32'hBBBB);
        chk("coll_conf", {31'd0, conf}, 32'd1);
        chk("coll_cnt", cnt, 32'd4);
        #1;
        drv(1, 0, 0, 0, 0, 0, 0, 4'b0000, 5, 5, 5);
        @(negedge clk);
        chk("coll_conf_clr", {31'd0, conf}, 32'd0);
        chk("coll_cnt_hold", cnt, 32'd4);
        #1;

        // Stall: nothing architectural changes
        drv(0, 1, 4, 32'h99, 0, 0, 0, 4'b1111, 4, 4, 4);
        @(negedge clk);
        chk("stall_r4", d0, 32'h0);
        chk("stall_flags", {28'd0, fz, fn, fc, fv}, 32'd0);
        chk("stall_cnt", cnt, 32'd4);
        #1;

        // Read-during-write on r6
        drv(1, 1, 6, 32'h1234, 0, 0, 0, 4'b0000, 6, 6, 6);
        #1;
`ifdef WB_BYPASS_EN
        chk("rdw_same_cycle", d0, 32'h1234);
`else
        chk("rdw_same_cycle", d0, 32'h0);
`endif
        @(negedge clk);
        chk("rdw_after_edge", d0, 32'h1234);
        chk("rdw_cnt", cnt, 32'd5);
        #1;

        // Asynchronous reset between edges
        drv(1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 4'b1111, 3, 3, 3);
        @(negedge clk);
        chk("pre_rst_r3", d0, 32'hDEADBEEF);
        chk("pre_rst_flags", {28'd0, fz, fn, fc, fv}, 32'hF);
        #1;
        drv(0, 0, 0, 0, 0, 0, 0, 4'b0000, 3, 3, 3);
        rst = 1'b1;
        #1;
        chk("async_rst_r3", d0, 32'h0);
        chk("async_rst_cnt", cnt, 32'h0);
        chk("async_rst_flags", {28'd0, fz, fn, fc, fv}, 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;

        // 16 writes: 4-bit counter wraps to 0
        drv(1, 1, 0, 32'h5, 1, 7, 32'h7, 4'b0101, 0, 7, 1);
        repeat (8) begin
            @(negedge clk);
            #1;
        end
        chk("wrap_cnt32", cnt, 32'd16);
        chk("wrap_cnt4", {28'd0, scnt}, 32'd0);
        drv(1, 0, 0, 0, 1, 1, 32'h1, 4'b0000, 0, 7, 1);
        @(negedge clk);
        chk("wrap_cnt4_next", {28'd0, scnt}, 32'd1);
        chk("wrap_cnt32_next", cnt, 32'd17);
        #1;

        // Randomised phase
        for (int i = 0; i < 3000; i++) begin
            drv(($urandom % 5) != 0, $urandom % 2, 3'($urandom), $urandom,
                $urandom % 2, 3'($urandom), $urandom, 4'($urandom),
                3'($urandom), 3'($urandom), 3'($urandom));
            if (($urandom % 4) == 0) mrd = ard;
            if (($urandom % 3) == 0) ra0 = mrd;
            if (($urandom % 3) == 0) ra1 = ard;
            rst = (($urandom % 64) == 0);
            @(negedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
